// File: rtl/trigger_histogrammer.sv
// trigger_histogrammer
// Counts rising edges on four asynchronous trigger inputs, with a programmable
// per-channel dead time after each counted edge, and measures the delay in
// clock cycles from a counted ch0 edge to the following counted ch1 edge.
// Hit counts and the last delay are exported as registered outputs for the
// serial command processor.

module trigger_histogrammer #(
  parameter int NCH      = 4,
  parameter int SAT_HIST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    trig_in,
  input  logic [7:0]        deadticks,
  input  logic              resethist,
  output logic [31:0]       histos [NCH],
  output logic [7:0]        delaycounter
);

  // Dead-time FSM encodings
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_DEAD   = 1'b1;

  // Delay FSM encodings
  localparam logic [0:0] ST_ARMED  = 1'b0;
  localparam logic [0:0] ST_TIMING = 1'b1;

  // ------------------------------------------------------------------------
  // Three-stage synchroniser; all stages reset high so a level that is
  // already high when reset is released is never seen as a rising edge.
  // ------------------------------------------------------------------------
  logic [NCH-1:0] s1_q, s1_d;
  logic [NCH-1:0] s2_q, s2_d;
  logic [NCH-1:0] s3_q, s3_d;
  logic [NCH-1:0] edge_raw;
  logic [NCH-1:0] counted;

  // Shift the trigger levels one stage per clock
  always_comb begin
    s1_d = trig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // Synchroniser registers, untouched by the histogram clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
      s3_q <= '1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign edge_raw = s2_q & ~s3_q;

  // ------------------------------------------------------------------------
  // Per-channel dead-time FSM and hit counter
  // ------------------------------------------------------------------------
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [0:0]  dstate_q, dstate_d;
    logic [7:0]  dc_q, dc_d;
    logic [31:0] cnt_q, cnt_d;

    // An edge counts only when the channel is idle and no clear is pending
    assign counted[i] = ~resethist & (dstate_q == ST_IDLE) & edge_raw[i];

    // Next dead-time state, down-counter and hit count
    always_comb begin
      dstate_d = dstate_q;
      dc_d     = dc_q;
      cnt_d    = cnt_q;
      if (resethist) begin
        dstate_d = ST_IDLE;
        dc_d     = 8'd0;
        cnt_d    = 32'd0;
      end else if (dstate_q == ST_IDLE) begin
        if (counted[i]) begin
          dc_d     = deadticks;
          dstate_d = (deadticks != 8'd0) ? ST_DEAD : ST_IDLE;
          if ((SAT_HIST != 0) && (cnt_q == 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
      end else begin
        dc_d = dc_q - 8'd1;
        if (dc_q <= 8'd1) begin
          dstate_d = ST_IDLE;
          dc_d     = 8'd0;
        end
      end
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dstate_q <= ST_IDLE;
        dc_q     <= 8'd0;
        cnt_q    <= 32'd0;
      end else begin
        dstate_q <= dstate_d;
        dc_q     <= dc_d;
        cnt_q    <= cnt_d;
      end
    end

    assign histos[i] = cnt_q;
  end

  // ------------------------------------------------------------------------
  // ch0 -> ch1 delay meter
  // ------------------------------------------------------------------------
  logic [0:0] dly_state_q, dly_state_d;
  logic [7:0] t_q, t_d;
  logic [7:0] delay_q, delay_d;
  logic [7:0] t_inc;

  assign t_inc = (t_q == 8'hFF) ? t_q : t_q + 8'd1;

  // Arm on ch0, stop on ch1; ch1 wins over a same-cycle ch0 while timing
  always_comb begin
    dly_state_d = dly_state_q;
    t_d         = t_q;
    delay_d     = delay_q;
    if (resethist) begin
      dly_state_d = ST_ARMED;
      t_d         = 8'd0;
    end else if (dly_state_q == ST_ARMED) begin
      if (counted[0] && counted[1]) begin
        delay_d = 8'd0;
      end else if (counted[0]) begin
        t_d         = 8'd0;
        dly_state_d = ST_TIMING;
      end
    end else begin
      t_d = t_inc;
      if (counted[1]) begin
        delay_d     = t_inc;
        dly_state_d = ST_ARMED;
      end else if (counted[0]) begin
        t_d = 8'd0;
      end
    end
  end

  // Delay meter registers; the measured value survives a histogram clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_state_q <= ST_ARMED;
      t_q         <= 8'd0;
      delay_q     <= 8'd0;
    end else begin
      dly_state_q <= dly_state_d;
      t_q         <= t_d;
      delay_q     <= delay_d;
    end
  end

  assign delaycounter = delay_q;

endmodule

// File: tb/tb_trigger_histogrammer.sv
// Directed testbench for trigger_histogrammer: reset behaviour, synchroniser
// latency, dead time, delay measurement, histogram clear, saturation/wrap and
// asynchronous reset. A second instance is built with wrapping counters.

module tb_trigger_histogrammer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  trig_in;
  logic [7:0]  deadticks;
  logic        resethist;
  logic [31:0] histos   [4];
  logic [7:0]  delaycounter;
  logic [31:0] histos_w [4];
  logic [7:0]  delaycounter_w;

  int checks = 0;
  int errors = 0;

  trigger_histogrammer #(.NCH(4), .SAT_HIST(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .trig_in      (trig_in),
    .deadticks    (deadticks),
    .resethist    (resethist),
    .histos       (histos),
    .delaycounter (delaycounter)
  );

  trigger_histogrammer #(.NCH(4), .SAT_HIST(0)) dut_wrap (
    .clk          (clk),
    .rst_n        (rst_n),
    .trig_in      (trig_in),
    .deadticks    (deadticks),
    .resethist    (resethist),
    .histos       (histos_w),
    .delaycounter (delaycounter_w)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Pulse the selected channels high for hi cycles, then low for lo cycles
  task automatic applyStimulus(input logic [3:0] mask, input int hi, input int lo);
    trig_in = trig_in | mask;
    step(hi);
    trig_in = trig_in & ~mask;
    step(lo);
  endtask

  task automatic clearHist();
    resethist = 1'b1;
    step(1);
    resethist = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_pre [4];
    exp_pre = '{32'd5, 32'd6, 32'd7, 32'd8};

    trig_in   = 4'b1111;
    deadticks = 8'd10;
    resethist = 1'b0;
    rst_n     = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(20);

    // Levels high across reset release must not count
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rst_hist%0d", i), histos[i], 32'd0);
      checkOutput($sformatf("rst_hist_w%0d", i), histos_w[i], 32'd0);
    end
    checkOutput("rst_delay", {24'd0, delaycounter}, 32'd0);
    checkOutput("rst_delay_w", {24'd0, delaycounter_w}, 32'd0);

    // ch2 drop then rise: count visible after the third edge
    trig_in[2] = 1'b0;
    step(5);
    trig_in[2] = 1'b1;
    step(1);
    checkOutput("lat_e0", histos[2], 32'd0);
    step(1);
    checkOutput("lat_e1", histos[2], 32'd0);
    step(1);
    checkOutput("lat_e2", histos[2], 32'd1);
    trig_in = 4'b0000;
    step(5);

    // Dead time 10 with rises every 4 cycles: counted at 0,12,24,36
    clearHist();
    deadticks = 8'd10;
    repeat (10) applyStimulus(4'b0001, 2, 2);
    step(15);
    checkOutput("dead10", histos[0], 32'd4);

    // No dead time: every rise counts
    deadticks = 8'd0;
    clearHist();
    repeat (10) applyStimulus(4'b0001, 2, 2);
    step(5);
    checkOutput("dead0", histos[0], 32'd10);

    // ch0 -> ch1 37 cycles apart
    clearHist();
    trig_in[0] = 1'b1;
    step(37);
    trig_in[1] = 1'b1;
    step(5);
    trig_in = 4'b0000;
    step(5);
    checkOutput("delay37", {24'd0, delaycounter}, 32'd37);

    // 300 cycles apart saturates
    trig_in[0] = 1'b1;
    step(300);
    trig_in[1] = 1'b1;
    step(5);
    trig_in = 4'b0000;
    step(5);
    checkOutput("delay300", {24'd0, delaycounter}, 32'd255);

    // Same-cycle ch0 and ch1
    trig_in = 4'b0011;
    step(5);
    trig_in = 4'b0000;
    step(5);
    checkOutput("delay_same", {24'd0, delaycounter}, 32'd0);

    // Retrigger: second ch0 20 cycles after first, ch1 15 later
    trig_in[0] = 1'b1;
    step(3);
    trig_in[0] = 1'b0;
    step(17);
    trig_in[0] = 1'b1;
    step(3);
    trig_in[0] = 1'b0;
    step(12);
    trig_in[1] = 1'b1;
    step(5);
    trig_in = 4'b0000;
    step(5);
    checkOutput("delay_retrig", {24'd0, delaycounter}, 32'd15);

    // Preload 5/6/7/8 with a final 7-cycle ch0 -> ch1 measurement
    clearHist();
    for (int p = 0; p < 8; p++) begin
      applyStimulus({(p < 8), (p < 7), (p < 5), (p < 4)}, 2, 2);
    end
    step(3);
    trig_in[0] = 1'b1;
    step(7);
    trig_in[1] = 1'b1;
    step(3);
    trig_in = 4'b0000;
    step(5);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("preload%0d", i), histos[i], exp_pre[i]);
    end
    checkOutput("preload_delay", {24'd0, delaycounter}, 32'd7);

    // One-cycle clear landing on the cycle the ch1 edge would count
    trig_in[1] = 1'b1;
    step(2);
    resethist = 1'b1;
    step(1);
    resethist = 1'b0;
    step(3);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("clr%0d", i), histos[i], 32'd0);
    end
    checkOutput("clr_delay_kept", {24'd0, delaycounter}, 32'd7);
    trig_in = 4'b0000;
    step(3);

    // Sustained clear while ch3 toggles, then counting resumes
    resethist = 1'b1;
    repeat (12) applyStimulus(4'b1000, 2, 2);
    step(2);
    checkOutput("hold_clr", histos[3], 32'd0);
    resethist = 1'b0;
    step(3);
    checkOutput("after_clr", histos[3], 32'd0);
    repeat (2) applyStimulus(4'b1000, 2, 2);
    step(3);
    checkOutput("resume", histos[3], 32'd2);

    // Counter at the top of its range: saturate vs wrap
    clearHist();
    force dut.g_ch[1].cnt_q = 32'hFFFF_FFFE;
    force dut_wrap.g_ch[1].cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.g_ch[1].cnt_q;
    release dut_wrap.g_ch[1].cnt_q;
    step(1);
    repeat (3) applyStimulus(4'b0010, 2, 2);
    step(3);
    checkOutput("sat", histos[1], 32'hFFFF_FFFF);
    checkOutput("wrap", histos_w[1], 32'h0000_0001);

    // Asynchronous reset while ch2 is dead and the delay meter is timing
    deadticks = 8'd10;
    clearHist();
    trig_in = 4'b0101;
    step(5);
    checkOutput("pre_rst_h0", histos[0], 32'd1);
    checkOutput("pre_rst_h2", histos[2], 32'd1);
    checkOutput("pre_rst_delay", {24'd0, delaycounter}, 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_h0", histos[0], 32'd0);
    checkOutput("async_h2", histos[2], 32'd0);
    checkOutput("async_delay", {24'd0, delaycounter}, 32'd0);
    trig_in = 4'b0000;
    step(2);
    rst_n = 1'b1;
    step(5);
    trig_in[2] = 1'b1;
    step(5);
    checkOutput("post_rst_h2", histos[2], 32'd1);
    checkOutput("post_rst_delay_w", {24'd0, delaycounter_w}, 32'd0);
    trig_in = 4'b0000;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
